// File: rtl/hex_display_mux.sv
// hex_display_mux
// Time-multiplexes two hex digits onto one shared 7-segment decoder and two
// common-anode displays. Each digit is preceded by a blanking interval, with
// both anodes off, so the decoder output settles before an anode turns on.
// New digit values are captured on a load strobe. They are applied only at
// frame boundaries, so both digits of one frame always belong together.
//
// Parameters:
//   DIV_CYCLES   - cycles each digit is lit (>= 1)
//   BLANK_CYCLES - cycles both anodes are off before each digit (0 = no blanking)
//
// Ports:
//   clk         - clock
//   reset       - synchronous, active-low reset
//   load        - capture strobe for digit0/digit1
//   digit0      - hex value for display 0
//   digit1      - hex value for display 1
//   s           - nibble to the segment decoder
//   an          - active-low anode enables (an[0] = display 0, an[1] = display 1)
//   blank       - high while both anodes are off
//   frame_start - one-cycle pulse on the first cycle of each frame
module hex_display_mux #(
  parameter int DIV_CYCLES   = 50000,
  parameter int BLANK_CYCLES = 500
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] digit0,
  input  logic [3:0] digit1,
  output logic [3:0] s,
  output logic [1:0] an,
  output logic       blank,
  output logic       frame_start
);

  localparam int MAX_LEN = (DIV_CYCLES > BLANK_CYCLES) ? DIV_CYCLES : BLANK_CYCLES;
  localparam int CW      = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam bit HAS_BLANK = (BLANK_CYCLES > 0);
  localparam logic [CW-1:0] DIV_LAST   = CW'(DIV_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(HAS_BLANK ? BLANK_CYCLES - 1 : 0);

  typedef enum logic [1:0] {
    BLANK0 = 2'd0,
    SHOW0  = 2'd1,
    BLANK1 = 2'd2,
    SHOW1  = 2'd3
  } state_t;

  // With no blanking the frame begins directly in SHOW0.
  localparam state_t FIRST_STATE = state_t'(HAS_BLANK ? 2'd0 : 2'd1);

  state_t          r_state;
  state_t          w_nextState;
  logic [CW-1:0]   r_counter;
  logic            w_stateDone;
  logic            w_frameWrap;
  logic [3:0]      r_pending0;
  logic [3:0]      r_pending1;
  logic [3:0]      r_disp0;
  logic [3:0]      r_disp1;

  // State register and dwell counter; the counter clears on every state change.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state   <= FIRST_STATE;
      r_counter <= '0;
    end else if (w_stateDone) begin
      r_state   <= w_nextState;
      r_counter <= '0;
    end else begin
      r_counter <= r_counter + CW'(1);
    end
  end

  // Next-state logic: each state ends when its counter reaches length-1.
  always_comb begin
    w_nextState = r_state;
    w_stateDone = 1'b0;
    case (r_state)
      BLANK0: begin
        w_stateDone = (r_counter == BLANK_LAST);
        w_nextState = SHOW0;
      end
      SHOW0: begin
        w_stateDone = (r_counter == DIV_LAST);
        w_nextState = HAS_BLANK ? BLANK1 : SHOW1;
      end
      BLANK1: begin
        w_stateDone = (r_counter == BLANK_LAST);
        w_nextState = SHOW1;
      end
      SHOW1: begin
        w_stateDone = (r_counter == DIV_LAST);
        w_nextState = HAS_BLANK ? BLANK0 : SHOW0;
      end
      default: begin
        w_stateDone = 1'b1;
        w_nextState = FIRST_STATE;
      end
    endcase
  end

  // Leaving SHOW1 is the edge that starts a new frame.
  assign w_frameWrap = (r_state == SHOW1) && w_stateDone;

  // Pending registers follow every load. The displayed pair only changes at a
  // frame boundary, and a load on that same edge goes straight to the display.
  always_ff @(posedge clk) begin
    if (!reset) begin
      r_pending0 <= 4'h0;
      r_pending1 <= 4'h0;
      r_disp0    <= 4'h0;
      r_disp1    <= 4'h0;
    end else begin
      if (load) begin
        r_pending0 <= digit0;
        r_pending1 <= digit1;
      end
      if (w_frameWrap) begin
        r_disp0 <= load ? digit0 : r_pending0;
        r_disp1 <= load ? digit1 : r_pending1;
      end
    end
  end

  // Moore output decode. Blank states pre-drive the upcoming digit so the
  // decoder has settled before its anode turns on. While reset is held, the
  // displays are forced dark, which also covers the no-blanking build whose
  // reset state is a SHOW state.
  always_comb begin
    an          = 2'b11;
    blank       = 1'b1;
    s           = r_disp0;
    frame_start = (r_state == FIRST_STATE) && (r_counter == '0);
    case (r_state)
      BLANK0: s = r_disp0;
      SHOW0: begin
        an    = 2'b10;
        blank = 1'b0;
        s     = r_disp0;
      end
      BLANK1: s = r_disp1;
      SHOW1: begin
        an    = 2'b01;
        blank = 1'b0;
        s     = r_disp1;
      end
      default: s = r_disp0;
    endcase
    if (!reset) begin
      an          = 2'b11;
      blank       = 1'b1;
      s           = 4'h0;
      frame_start = 1'b0;
    end
  end

endmodule
